// File: rtl/aes_shiftmix.sv
// aes_shiftmix: column-serial ShiftRows + MixColumns stage; buffers four columns, then drains four round columns.
module aes_shiftmix (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] din,
  input  logic        din_vld,
  output logic        din_rdy,
  input  logic        last_round,
  output logic [31:0] dout,
  output logic        dout_vld,
  input  logic        dout_rdy
);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic lr_q, lr_d;
  logic [3:0][31:0] st_q, st_d;
  logic [31:0] sr;
  logic [1:0] idx;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  always_comb begin
    sr = '0;
    idx = '0;
    for (int r = 0; r < 4; r++) begin
      idx = cnt_q + 2'(r);
      sr[31-8*r -: 8] = st_q[idx][31-8*r -: 8];
    end
    dout = lr_q ? sr : mix(sr);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    lr_d = lr_q;
    st_d = st_q;
    din_rdy = state_q == FILL;
    dout_vld = state_q == DRAIN;
    if (din_rdy && din_vld) begin
      st_d[cnt_q] = din;
      lr_d = cnt_q == 2'd0 ? last_round : lr_q;
      cnt_d = cnt_q + 2'd1;
      state_d = cnt_q == 2'd3 ? DRAIN : FILL;
    end
    if (dout_vld && dout_rdy) begin
      cnt_d = cnt_q + 2'd1;
      state_d = cnt_q == 2'd3 ? FILL : DRAIN;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= FILL;
      cnt_q <= '0;
      lr_q <= 1'b0;
      st_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lr_q <= lr_d;
      st_q <= st_d;
    end
  end
endmodule

// File: tb/tb_aes_shiftmix.sv
// tb_aes_shiftmix: directed vectors with hand-computed results for aes_shiftmix.
module tb_aes_shiftmix;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic [31:0] din = '0;
  logic din_vld = 1'b0;
  logic din_rdy;
  logic last_round = 1'b0;
  logic [31:0] dout;
  logic dout_vld;
  logic dout_rdy = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  aes_shiftmix dut (
    .CLK(CLK), .RSTn(RSTn), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .last_round(last_round), .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on negedge; the rising edge in between performs the handshake.
  task automatic send(input logic [31:0] w, input logic l);
    int n;
    n = 0;
    din = w;
    din_vld = 1'b1;
    last_round = l;
    while (din_rdy !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
    @(negedge CLK);
    din_vld = 1'b0;
  endtask

  task automatic recv(input logic [31:0] exp, input string tag);
    int n;
    n = 0;
    dout_rdy = 1'b1;
    while (dout_vld !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk({tag, "_timeout"}, 32'(n), 32'd0);
    chk(tag, dout, exp);
    chk({tag, "_din_rdy"}, 32'(din_rdy), 32'd0);
    @(negedge CLK);
    dout_rdy = 1'b0;
  endtask

  initial begin
    logic [31:0] sr_in [4];
    logic [31:0] sr_out [4];
    sr_in = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    sr_out = '{32'h00050a0f, 32'h04090e03, 32'h080d0207, 32'h0c01060b};
    repeat (2) @(negedge CLK);
    chk("rst_din_rdy_low", 32'(din_rdy), 32'd1);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("rst_din_rdy", 32'(din_rdy), 32'd1);
    chk("rst_dout_vld", 32'(dout_vld), 32'd0);

    // ShiftRows only, back-to-back, with latency and throughput checked per cycle
    for (int i = 0; i < 4; i++) begin
      din = sr_in[i]; din_vld = 1'b1; last_round = 1'b1;
      chk("sr_fill_rdy", 32'(din_rdy), 32'd1);
      chk("sr_fill_vld", 32'(dout_vld), 32'd0);
      @(negedge CLK);
    end
    din_vld = 1'b0;
    dout_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("sr_vld", 32'(dout_vld), 32'd1);
      chk("sr_dout", dout, sr_out[i]);
      @(negedge CLK);
    end
    dout_rdy = 1'b0;
    chk("sr_back_fill", 32'(din_rdy), 32'd1);

    for (int i = 0; i < 4; i++) send(32'hdb135345, 1'b0);
    for (int i = 0; i < 4; i++) recv(32'h8e4da1bc, "mc_db");
    for (int i = 0; i < 4; i++) send(32'hf20a225c, 1'b0);
    for (int i = 0; i < 4; i++) recv(32'h9fdc589d, "mc_f2");
    for (int i = 0; i < 4; i++) send(32'h01010101, 1'b0);
    for (int i = 0; i < 4; i++) recv(32'h01010101, "mc_01");

    // Backpressure on column 1 while a word is offered upstream
    for (int i = 0; i < 4; i++) send(sr_in[i], 1'b1);
    recv(sr_out[0], "bp_c0");
    din = 32'hdeadbeef; din_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", dout, sr_out[1]);
      chk("bp_vld", 32'(dout_vld), 32'd1);
      chk("bp_din_rdy", 32'(din_rdy), 32'd0);
      @(negedge CLK);
    end
    din_vld = 1'b0;
    for (int i = 1; i < 4; i++) recv(sr_out[i], "bp_resume");

    // Mid-block reset discards the partial block
    send(32'hdb135345, 1'b0);
    send(32'hdb135345, 1'b0);
    RSTn = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    chk("mid_rst_rdy", 32'(din_rdy), 32'd1);
    chk("mid_rst_vld", 32'(dout_vld), 32'd0);
    for (int i = 0; i < 4; i++) send(sr_in[i], 1'b1);
    for (int i = 0; i < 4; i++) recv(sr_out[i], "mid_rst_out");

    // last_round is only taken with word 0
    send(32'hdb135345, 1'b0);
    for (int i = 1; i < 4; i++) send(32'hdb135345, 1'b1);
    for (int i = 0; i < 4; i++) recv(32'h8e4da1bc, "lr0_toggle");
    send(sr_in[0], 1'b1);
    for (int i = 1; i < 4; i++) send(sr_in[i], 1'b0);
    for (int i = 0; i < 4; i++) recv(sr_out[i], "lr1_toggle");

    // Gaps between input words
    for (int i = 0; i < 4; i++) begin
      send(sr_in[i], 1'b1);
      repeat (2) @(negedge CLK);
      if (i < 3) chk("gap_no_vld", 32'(dout_vld), 32'd0);
    end
    for (int i = 0; i < 4; i++) recv(sr_out[i], "gap_out");

    // Next block offered during DRAIN waits for FILL
    for (int i = 0; i < 4; i++) send(32'hdb135345, 1'b0);
    din = 32'hf20a225c; din_vld = 1'b1; last_round = 1'b0;
    for (int i = 0; i < 4; i++) recv(32'h8e4da1bc, "b2b_first");
    chk("b2b_fill_rdy", 32'(din_rdy), 32'd1);
    for (int i = 0; i < 4; i++) send(32'hf20a225c, 1'b0);
    for (int i = 0; i < 4; i++) recv(32'h9fdc589d, "b2b_second");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
